// File: rtl/sys_cmd_ctrl.sv
// Byte-framed command controller: RF write/read and gated ALU ops,
// with multi-byte result push to the TX FIFO, frame timeout and error pulse.
module sys_cmd_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int FUN_W      = 4,
  parameter int RES_W      = 16,
  parameter int GATE_SETUP = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_DATA,
  input  logic              RX_VALID,
  input  logic              FIFO_FULL,
  input  logic [DATA_W-1:0] RF_RD_DATA,
  input  logic              RF_RD_VALID,
  input  logic [RES_W-1:0]  ALU_OUT,
  input  logic              ALU_VALID,
  output logic [DATA_W-1:0] FIFO_WR_DATA,
  output logic              FIFO_WR_INC,
  output logic [ADDR_W-1:0] RF_ADDR,
  output logic [DATA_W-1:0] RF_WR_DATA,
  output logic              RF_WR_EN,
  output logic              RF_RD_EN,
  output logic [FUN_W-1:0]  ALU_FUN,
  output logic              ALU_EN,
  output logic              GATE_EN,
  output logic              BUSY,
  output logic              CMD_ERR
);

  localparam int NB  = RES_W / DATA_W;
  localparam int NBW = $clog2(NB + 1);

  localparam logic [DATA_W-1:0] CMD_WR  = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] CMD_RD  = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] CMD_OP  = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] CMD_NOP = DATA_W'(8'hDD);

  localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);
  localparam logic [7:0] GS_M1 = 8'(GATE_SETUP - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_OP_A,
    S_OP_B,
    S_FUN,
    S_GATE,
    S_ALU_WAIT,
    S_PUSH
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        cnt_q, cnt_d;
  logic [NBW-1:0]    nb_q, nb_d;
  logic [RES_W-1:0]  res_q, res_d;

  logic [DATA_W-1:0] fifo_wr_data_q, fifo_wr_data_d;
  logic              fifo_wr_inc_q, fifo_wr_inc_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic              rf_rd_en_q, rf_rd_en_d;
  logic [FUN_W-1:0]  alu_fun_q, alu_fun_d;
  logic              alu_en_q, alu_en_d;
  logic              gate_en_q, gate_en_d;
  logic              busy_q, busy_d;
  logic              cmd_err_q, cmd_err_d;

  logic addr_bad;
  logic to_hit;
  logic abort;

  assign addr_bad = |RX_DATA[DATA_W-1:ADDR_W];
  assign to_hit   = (cnt_q == TO_M1);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    nb_d           = nb_q;
    res_d          = res_q;
    fifo_wr_data_d = fifo_wr_data_q;
    fifo_wr_inc_d  = 1'b0;
    rf_addr_d      = rf_addr_q;
    rf_wr_data_d   = rf_wr_data_q;
    rf_wr_en_d     = 1'b0;
    rf_rd_en_d     = 1'b0;
    alu_fun_d      = alu_fun_q;
    alu_en_d       = alu_en_q;
    gate_en_d      = gate_en_q;
    cmd_err_d      = 1'b0;
    abort          = 1'b0;

    if (RX_VALID) cnt_d = '0;

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        alu_en_d  = 1'b0;
        gate_en_d = 1'b0;
        if (RX_VALID) begin
          if (RX_DATA == CMD_WR)       state_d = S_WR_ADDR;
          else if (RX_DATA == CMD_RD)  state_d = S_RD_ADDR;
          else if (RX_DATA == CMD_OP)  state_d = S_OP_A;
          else if (RX_DATA == CMD_NOP) state_d = S_FUN;
          else                         cmd_err_d = 1'b1;
        end
      end

      S_WR_ADDR: begin
        if (RX_VALID) begin
          if (addr_bad) begin
            cmd_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            rf_addr_d = RX_DATA[ADDR_W-1:0];
            state_d   = S_WR_DATA;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          abort = to_hit;
        end
      end

      S_WR_DATA: begin
        if (RX_VALID) begin
          rf_wr_data_d = RX_DATA;
          rf_wr_en_d   = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          abort = to_hit;
        end
      end

      S_RD_ADDR: begin
        if (RX_VALID) begin
          if (addr_bad) begin
            cmd_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            rf_addr_d  = RX_DATA[ADDR_W-1:0];
            rf_rd_en_d = 1'b1;
            state_d    = S_RD_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          abort = to_hit;
        end
      end

      S_RD_WAIT: begin
        if (RX_VALID) cmd_err_d = 1'b1;
        if (RF_RD_VALID) begin
          res_d   = RES_W'(RF_RD_DATA);
          nb_d    = NBW'(1);
          state_d = S_PUSH;
        end else if (!RX_VALID) begin
          cnt_d = cnt_q + 8'd1;
          abort = to_hit;
        end
      end

      // Operand A lands in RF[0], operand B in RF[1].
      S_OP_A: begin
        if (RX_VALID) begin
          rf_addr_d    = '0;
          rf_wr_data_d = RX_DATA;
          rf_wr_en_d   = 1'b1;
          state_d      = S_OP_B;
        end else begin
          cnt_d = cnt_q + 8'd1;
          abort = to_hit;
        end
      end

      S_OP_B: begin
        if (RX_VALID) begin
          rf_addr_d    = ADDR_W'(1);
          rf_wr_data_d = RX_DATA;
          rf_wr_en_d   = 1'b1;
          state_d      = S_FUN;
        end else begin
          cnt_d = cnt_q + 8'd1;
          abort = to_hit;
        end
      end

      S_FUN: begin
        if (RX_VALID) begin
          alu_fun_d = RX_DATA[FUN_W-1:0];
          gate_en_d = 1'b1;
          state_d   = S_GATE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          abort = to_hit;
        end
      end

      // cnt doubles as the clock-gate settle counter; overruns must not reset it.
      S_GATE: begin
        if (RX_VALID) cmd_err_d = 1'b1;
        if (cnt_q == GS_M1) begin
          alu_en_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_ALU_WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_ALU_WAIT: begin
        if (RX_VALID) cmd_err_d = 1'b1;
        if (ALU_VALID) begin
          res_d    = ALU_OUT;
          nb_d     = NBW'(NB);
          alu_en_d = 1'b0;
          state_d  = S_PUSH;
        end else if (!RX_VALID) begin
          cnt_d = cnt_q + 8'd1;
          abort = to_hit;
        end
      end

      S_PUSH: begin
        if (RX_VALID) cmd_err_d = 1'b1;
        if (!FIFO_FULL) begin
          fifo_wr_inc_d  = 1'b1;
          fifo_wr_data_d = res_q[DATA_W-1:0];
          res_d          = res_q >> DATA_W;
          nb_d           = nb_q - NBW'(1);
          if (nb_q == NBW'(1)) begin
            gate_en_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
      end

      default: begin
        alu_en_d  = 1'b0;
        gate_en_d = 1'b0;
        cnt_d     = '0;
        state_d   = S_IDLE;
      end
    endcase

    if (abort) begin
      cmd_err_d  = 1'b1;
      rf_wr_en_d = 1'b0;
      rf_rd_en_d = 1'b0;
      alu_en_d   = 1'b0;
      gate_en_d  = 1'b0;
      cnt_d      = '0;
      state_d    = S_IDLE;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      nb_q           <= '0;
      res_q          <= '0;
      fifo_wr_data_q <= '0;
      fifo_wr_inc_q  <= 1'b0;
      rf_addr_q      <= '0;
      rf_wr_data_q   <= '0;
      rf_wr_en_q     <= 1'b0;
      rf_rd_en_q     <= 1'b0;
      alu_fun_q      <= '0;
      alu_en_q       <= 1'b0;
      gate_en_q      <= 1'b0;
      busy_q         <= 1'b0;
      cmd_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      nb_q           <= nb_d;
      res_q          <= res_d;
      fifo_wr_data_q <= fifo_wr_data_d;
      fifo_wr_inc_q  <= fifo_wr_inc_d;
      rf_addr_q      <= rf_addr_d;
      rf_wr_data_q   <= rf_wr_data_d;
      rf_wr_en_q     <= rf_wr_en_d;
      rf_rd_en_q     <= rf_rd_en_d;
      alu_fun_q      <= alu_fun_d;
      alu_en_q       <= alu_en_d;
      gate_en_q      <= gate_en_d;
      busy_q         <= busy_d;
      cmd_err_q      <= cmd_err_d;
    end
  end

  assign FIFO_WR_DATA = fifo_wr_data_q;
  assign FIFO_WR_INC  = fifo_wr_inc_q;
  assign RF_ADDR      = rf_addr_q;
  assign RF_WR_DATA   = rf_wr_data_q;
  assign RF_WR_EN     = rf_wr_en_q;
  assign RF_RD_EN     = rf_rd_en_q;
  assign ALU_FUN      = alu_fun_q;
  assign ALU_EN       = alu_en_q;
  assign GATE_EN      = gate_en_q;
  assign BUSY         = busy_q;
  assign CMD_ERR      = cmd_err_q;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed bench for sys_cmd_ctrl: command vector table plus
// hand sequences for gating, FIFO back-pressure, overrun, reset and timeout.
module tb_sys_cmd_ctrl;

  logic        CLK;
  logic        RST;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        FIFO_FULL;
  logic [7:0]  RF_RD_DATA;
  logic        RF_RD_VALID;
  logic [15:0] ALU_OUT;
  logic        ALU_VALID;
  logic [7:0]  FIFO_WR_DATA;
  logic        FIFO_WR_INC;
  logic [3:0]  RF_ADDR;
  logic [7:0]  RF_WR_DATA;
  logic        RF_WR_EN;
  logic        RF_RD_EN;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic        GATE_EN;
  logic        BUSY;
  logic        CMD_ERR;

  sys_cmd_ctrl dut (
    .CLK(CLK), .RST(RST),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .FIFO_FULL(FIFO_FULL),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_VALID(RF_RD_VALID),
    .ALU_OUT(ALU_OUT), .ALU_VALID(ALU_VALID),
    .FIFO_WR_DATA(FIFO_WR_DATA), .FIFO_WR_INC(FIFO_WR_INC),
    .RF_ADDR(RF_ADDR), .RF_WR_DATA(RF_WR_DATA),
    .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .GATE_EN(GATE_EN),
    .BUSY(BUSY), .CMD_ERR(CMD_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  logic [7:0] rf_mem [16];
  logic [3:0] wr_a [$];
  logic [7:0] wr_d [$];
  logic [7:0] push_q [$];
  int rd_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int last_push_cyc = 0;
  int gate_rise_cyc = 0;
  int gate_fall_cyc = 0;
  int alu_rise_cyc = 0;
  int last_rx_cyc = 0;
  logic gate_prev = 1'b0;
  logic alu_prev = 1'b0;
  int alu_cnt = 0;
  logic alu_req = 1'b0;
  logic rd_req = 1'b0;
  logic [3:0] rd_addr_s = '0;
  logic rf_resp_en = 1'b1;
  logic [15:0] alu_val = '0;

  always @(negedge CLK) begin
    if (RF_WR_EN) begin
      wr_a.push_back(RF_ADDR);
      wr_d.push_back(RF_WR_DATA);
      rf_mem[RF_ADDR] = RF_WR_DATA;
    end
    if (RF_RD_EN) begin
      rd_cnt++;
      rd_addr_s = RF_ADDR;
      if (rf_resp_en) rd_req = 1'b1;
    end
    if (FIFO_WR_INC) begin
      push_q.push_back(FIFO_WR_DATA);
      last_push_cyc = cyc;
    end
    if (CMD_ERR) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (GATE_EN && !gate_prev) gate_rise_cyc = cyc;
    if (!GATE_EN && gate_prev) gate_fall_cyc = cyc;
    if (ALU_EN && !alu_prev) alu_rise_cyc = cyc;
    gate_prev = GATE_EN;
    alu_prev = ALU_EN;
    if (ALU_EN) alu_cnt++;
    else alu_cnt = 0;
    if (alu_cnt == 2) alu_req = 1'b1;
  end

  always @(posedge CLK) begin
    cyc++;
    #1;
    if (rf_resp_en) begin
      RF_RD_VALID = rd_req;
      RF_RD_DATA = rf_mem[rd_addr_s];
      rd_req = 1'b0;
    end
    ALU_VALID = alu_req;
    ALU_OUT = alu_val;
    alu_req = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1;
    RX_DATA = b;
    RX_VALID = 1'b1;
    @(posedge CLK);
    #1;
    last_rx_cyc = cyc;
    RX_VALID = 1'b0;
  endtask

  task automatic clear_logs();
    wr_a.delete();
    wr_d.delete();
    push_q.delete();
    rd_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    repeat (2) tick();
    while (BUSY && k < 300) begin
      tick();
      k++;
    end
    chk(nm, {31'd0, BUSY}, 32'd0);
    repeat (2) tick();
  endtask

  function automatic logic [15:0] push_word();
    logic [15:0] w;
    w = '0;
    if (push_q.size() > 0) w[7:0] = push_q[0];
    if (push_q.size() > 1) w[15:8] = push_q[1];
    return w;
  endfunction

  typedef struct packed {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    int          n;
    logic [15:0] alu;
    int          wr_n;
    logic [3:0]  wa;
    logic [7:0]  wd;
    int          rd_n;
    int          push_n;
    logic [15:0] pw;
    int          err_n;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [7:0] bytes [4];
    int t0;
    int k;
    RST = 1'b0;
    RX_DATA = '0;
    RX_VALID = 1'b0;
    FIFO_FULL = 1'b0;
    RF_RD_DATA = '0;
    RF_RD_VALID = 1'b0;
    ALU_OUT = '0;
    ALU_VALID = 1'b0;
    for (int i = 0; i < 16; i++) rf_mem[i] = '0;
    rf_mem[2] = 8'hA5;

    //      b0     b1     b2     b3   n  alu       wr wa    wd     rd pn pw        err
    vt[0] = '{8'hAA, 8'h05, 8'h3C, 8'h00, 3, 16'h0000, 1, 4'h5, 8'h3C, 0, 0, 16'h0000, 0};
    vt[1] = '{8'hBB, 8'h02, 8'h00, 8'h00, 2, 16'h0000, 0, 4'h0, 8'h00, 1, 1, 16'h00A5, 0};
    vt[2] = '{8'hCC, 8'h12, 8'h34, 8'h01, 4, 16'h0046, 2, 4'h1, 8'h34, 0, 2, 16'h0046, 0};
    vt[3] = '{8'hDD, 8'h07, 8'h00, 8'h00, 2, 16'hBEEF, 0, 4'h0, 8'h00, 0, 2, 16'hBEEF, 0};
    vt[4] = '{8'h7E, 8'h00, 8'h00, 8'h00, 1, 16'h0000, 0, 4'h0, 8'h00, 0, 0, 16'h0000, 1};
    vt[5] = '{8'hAA, 8'h20, 8'h00, 8'h00, 2, 16'h0000, 0, 4'h0, 8'h00, 0, 0, 16'h0000, 1};
    vt[6] = '{8'hBB, 8'h1F, 8'h00, 8'h00, 2, 16'h0000, 0, 4'h0, 8'h00, 0, 0, 16'h0000, 1};
    vt[7] = '{8'hAA, 8'h0F, 8'hFF, 8'h00, 3, 16'h0000, 1, 4'hF, 8'hFF, 0, 0, 16'h0000, 0};
    vt[8] = '{8'hBB, 8'h0F, 8'h00, 8'h00, 2, 16'h0000, 0, 4'h0, 8'h00, 1, 1, 16'h00FF, 0};
    vt[9] = '{8'h00, 8'h00, 8'h00, 8'h00, 1, 16'h0000, 0, 4'h0, 8'h00, 0, 0, 16'h0000, 1};

    repeat (3) tick();
    chk("reset_outs",
        {1'b0, FIFO_WR_DATA, FIFO_WR_INC, RF_ADDR, RF_WR_DATA, RF_WR_EN,
         RF_RD_EN, ALU_FUN, ALU_EN, GATE_EN, BUSY, CMD_ERR}, 32'd0);
    RST = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 10; i++) begin
      clear_logs();
      alu_val = vt[i].alu;
      bytes[0] = vt[i].b0;
      bytes[1] = vt[i].b1;
      bytes[2] = vt[i].b2;
      bytes[3] = vt[i].b3;
      for (int j = 0; j < vt[i].n; j++) send_byte(bytes[j]);
      wait_idle($sformatf("v%0d_idle", i));
      chk($sformatf("v%0d_wr_n", i), wr_a.size(), vt[i].wr_n);
      if (wr_a.size() > 0) begin
        chk($sformatf("v%0d_wr_addr", i), wr_a[wr_a.size()-1], vt[i].wa);
        chk($sformatf("v%0d_wr_data", i), wr_d[wr_d.size()-1], vt[i].wd);
      end
      chk($sformatf("v%0d_rd_n", i), rd_cnt, vt[i].rd_n);
      chk($sformatf("v%0d_push_n", i), push_q.size(), vt[i].push_n);
      chk($sformatf("v%0d_push_data", i), push_word(), vt[i].pw);
      chk($sformatf("v%0d_err_n", i), err_cnt, vt[i].err_n);
    end

    // Operand writes, gate setup latency and GATE_EN drop with the last push.
    clear_logs();
    alu_val = 16'h1234;
    send_byte(8'hCC);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h09);
    wait_idle("gate_idle");
    chk("gate_wr0_addr", wr_a.size() > 0 ? wr_a[0] : 4'hX, 4'h0);
    chk("gate_wr0_data", wr_d.size() > 0 ? wr_d[0] : 8'hXX, 8'hAB);
    chk("gate_wr1_data", wr_d.size() > 1 ? wr_d[1] : 8'hXX, 8'hCD);
    chk("gate_alu_fun", ALU_FUN, 4'h9);
    chk("gate_setup", alu_rise_cyc - gate_rise_cyc, 3);
    chk("gate_drop_last_push", gate_fall_cyc, last_push_cyc);
    chk("gate_push", push_word(), 16'h1234);
    chk("gate_en_off", GATE_EN, 1'b0);

    // FIFO back-pressure: nothing pushed while full, then order kept.
    clear_logs();
    alu_val = 16'hC3A5;
    FIFO_FULL = 1'b1;
    t0 = cyc;
    send_byte(8'hDD);
    send_byte(8'h02);
    k = 0;
    while (!(alu_rise_cyc > t0 && !ALU_EN) && k < 60) begin
      tick();
      k++;
    end
    chk("full_alu_done", k < 60, 1'b1);
    repeat (5) tick();
    chk("full_no_push", push_q.size(), 0);
    chk("full_busy", BUSY, 1'b1);
    FIFO_FULL = 1'b0;
    wait_idle("full_idle");
    chk("full_push_n", push_q.size(), 2);
    chk("full_push_data", push_word(), 16'hC3A5);

    // Overrun during RD_WAIT: byte dropped, error, read completes.
    clear_logs();
    rf_resp_en = 1'b0;
    send_byte(8'hBB);
    send_byte(8'h04);
    send_byte(8'h55);
    @(posedge CLK);
    #1;
    RF_RD_DATA = 8'h5A;
    RF_RD_VALID = 1'b1;
    @(posedge CLK);
    #1;
    RF_RD_VALID = 1'b0;
    rf_resp_en = 1'b1;
    wait_idle("ovr_idle");
    chk("ovr_err", err_cnt, 1);
    chk("ovr_rd_n", rd_cnt, 1);
    chk("ovr_push_n", push_q.size(), 1);
    chk("ovr_push_data", push_word(), 16'h005A);

    // Reset in the middle of an ALU op.
    clear_logs();
    send_byte(8'hDD);
    send_byte(8'h03);
    tick();
    RST = 1'b0;
    #1;
    chk("rst_mid_outs",
        {1'b0, FIFO_WR_DATA, FIFO_WR_INC, RF_ADDR, RF_WR_DATA, RF_WR_EN,
         RF_RD_EN, ALU_FUN, ALU_EN, GATE_EN, BUSY, CMD_ERR}, 32'd0);
    repeat (2) tick();
    RST = 1'b1;
    repeat (10) tick();
    chk("rst_no_push", push_q.size(), 0);
    chk("rst_no_err", err_cnt, 0);
    chk("rst_gate_off", GATE_EN, 1'b0);
    clear_logs();
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h22);
    wait_idle("rst_after_idle");
    chk("rst_after_wr", {wr_a.size() == 1, wr_a.size() > 0 ? wr_d[0] : 8'h00}, 9'h122);

    // Timeout after an address byte, then a normal write.
    clear_logs();
    send_byte(8'hAA);
    send_byte(8'h03);
    t0 = last_rx_cyc;
    k = 0;
    while (err_cnt == 0 && k < 400) begin
      tick();
      k++;
    end
    chk("to_seen", err_cnt, 1);
    chk("to_delay", err_cyc - t0, 255);
    chk("to_busy", BUSY, 1'b0);
    chk("to_no_wr", wr_a.size(), 0);
    clear_logs();
    send_byte(8'hAA);
    send_byte(8'h03);
    send_byte(8'h11);
    wait_idle("to_after_idle");
    chk("to_after_wr_n", wr_a.size(), 1);
    chk("to_after_wr", wr_a.size() > 0 ? {wr_a[0], wr_d[0]} : 12'h000, 12'h311);
    chk("to_after_err", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
